// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Covers sequencing states, forwarding select codes and the default drain length.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// EX-operand forwarding select for one ALU source.
// The youngest producer (MEM) wins over WB, and x0 is never forwarded.
module fwd_sel
    import pipe_hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_we,
    input  logic [4:0] wb_rd,
    input  logic       wb_we,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding, load-use
// bubbles, redirect flushes, halt drain and the retired-instruction counter.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int PC_W      = 12,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_halt,
    input  logic [4:0]      ex_rs1,
    input  logic [4:0]      ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [4:0]      mem_rd,
    input  logic            mem_we,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic            wb_valid,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            pc_redirect,
    output logic [PC_W-1:0] pc_target,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            halt,
    output logic [31:0]     num_inst
);

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [31:0]      num_inst_q, num_inst_d;
    logic [1:0]       fwd_a_raw, fwd_b_raw;
    logic             load_use;

    fwd_sel u_fwd_a (
        .rs     (ex_rs1),
        .mem_rd (mem_rd),
        .mem_we (mem_we),
        .wb_rd  (wb_rd),
        .wb_we  (wb_we),
        .sel    (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .rs     (ex_rs2),
        .mem_rd (mem_rd),
        .mem_we (mem_we),
        .wb_rd  (wb_rd),
        .wb_we  (wb_we),
        .sel    (fwd_b_raw)
    );

    // ex_we is implied for loads; only the load flag matters for the bubble.
    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        num_inst_d  = num_inst_q + 32'(wb_valid);
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;

        unique case (state_q)
            ST_RUN: begin
                // Redirect wins: the halt or load in ID is on the wrong path.
                if (ex_redirect) begin
                    pc_redirect = 1'b1;
                    pc_target   = ex_target;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end else if (id_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = CNT_W'(DRAIN_CYC - 1);
                    pc_stall    = 1'b1;
                    ifid_flush  = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_flush  = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            ST_HALTED: begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!RSTn) begin
            state_d     = ST_RUN;
            drain_cnt_d = '0;
            num_inst_d  = '0;
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            pc_redirect = 1'b0;
            pc_target   = '0;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end
    end

    always_ff @(posedge CLK) begin
        state_q     <= state_d;
        drain_cnt_q <= drain_cnt_d;
        num_inst_q  <= num_inst_d;
    end

    assign halt     = (state_q == ST_HALTED);
    assign num_inst = num_inst_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int PC_W      = 12;
    localparam int DRAIN_CYC = 3;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic [4:0]      id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_use_rs1, id_use_rs2, id_halt, ex_we, ex_is_load;
    logic            mem_we, wb_we, wb_valid, ex_redirect;
    logic [PC_W-1:0] ex_target;
    logic            pc_stall, ifid_stall, ifid_flush, idex_flush, pc_redirect, halt;
    logic [PC_W-1:0] pc_target;
    logic [1:0]      fwd_a, fwd_b;
    logic [31:0]     num_inst;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_halt(id_halt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd),
        .wb_we(wb_we), .wb_valid(wb_valid), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halt(halt), .num_inst(num_inst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [4:0] rs, input logic [4:0] mrd,
                                        input logic mwe, input logic [4:0] wrd, input logic wwe);
        if (mwe && mrd != 0 && mrd == rs) return 2'b01;
        if (wwe && wrd != 0 && wrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    // Model: m_since counts edges since the halt was accepted (0 = running).
    int          m_since = 0;
    logic [31:0] m_cnt   = 0;
    bit          m_known = 0;

    always @(negedge CLK) begin : compare
        logic e_ps, e_is, e_if, e_ix, e_pr;
        logic [PC_W-1:0] e_tg;
        logic [1:0] e_fa, e_fb;
        logic lu;
        e_ps = 0; e_is = 0; e_if = 0; e_ix = 0; e_pr = 0; e_tg = '0; e_fa = 0; e_fb = 0;
        lu = ex_is_load && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (RSTn && m_known) begin
            e_fa = fsel(ex_rs1, mem_rd, mem_we, wb_rd, wb_we);
            e_fb = fsel(ex_rs2, mem_rd, mem_we, wb_rd, wb_we);
            if (m_since == 0) begin
                if (ex_redirect) begin
                    e_pr = 1; e_tg = ex_target; e_if = 1; e_ix = 1;
                end else if (id_halt) begin
                    e_ps = 1; e_if = 1;
                end else if (lu) begin
                    e_ps = 1; e_is = 1; e_ix = 1;
                end
            end else if (m_since <= DRAIN_CYC) begin
                e_ps = 1; e_if = 1;
            end else begin
                e_ps = 1; e_if = 1; e_ix = 1;
            end
        end
        if (m_known || !RSTn) begin
            chk("pc_stall", 32'(pc_stall), 32'(e_ps));
            chk("ifid_stall", 32'(ifid_stall), 32'(e_is));
            chk("ifid_flush", 32'(ifid_flush), 32'(e_if));
            chk("idex_flush", 32'(idex_flush), 32'(e_ix));
            chk("pc_redirect", 32'(pc_redirect), 32'(e_pr));
            chk("pc_target", 32'(pc_target), 32'(e_tg));
            chk("fwd_a", 32'(fwd_a), 32'(e_fa));
            chk("fwd_b", 32'(fwd_b), 32'(e_fb));
        end
        if (m_known) begin
            chk("halt", 32'(halt), 32'(m_since > DRAIN_CYC));
            chk("num_inst", num_inst, m_cnt);
        end
        // Advance the model to the state after the coming posedge.
        if (!RSTn) begin
            m_since = 0; m_cnt = 0; m_known = 1;
        end else if (m_known) begin
            m_cnt = m_cnt + 32'(wb_valid);
            if (m_since == 0) begin
                if (id_halt && !ex_redirect) m_since = 1;
            end else if (m_since <= DRAIN_CYC) begin
                m_since++;
            end
        end
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_halt = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0;
        mem_rd = 0; mem_we = 0; wb_rd = 0; wb_we = 0; wb_valid = 0;
        ex_redirect = 0; ex_target = 0;
    endtask

    // Advance one cycle: inputs change just after the edge, then settle before checks.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        RSTn = 0; idle();
        step(); step();
        RSTn = 1;
    endtask

    initial begin
        idle();
        // Reset state
        step();
        ex_rs1 = 5; mem_rd = 5; mem_we = 1; ex_redirect = 1; ex_target = 12'h40;
        settle();
        chk("rst_fwd_a", 32'(fwd_a), 32'h0);
        chk("rst_pc_redirect", 32'(pc_redirect), 32'h0);
        chk("rst_pc_target", 32'(pc_target), 32'h0);
        idle();
        step(); RSTn = 1; settle();
        chk("rst_num_inst", num_inst, 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);

        // MEM beats WB; x0 never forwarded
        step();
        ex_rs1 = 5; mem_rd = 5; mem_we = 1; wb_rd = 5; wb_we = 1; settle();
        chk("fwd_mem_over_wb", 32'(fwd_a), 32'h1);
        step();
        ex_rs2 = 0; mem_rd = 0; mem_we = 1; wb_rd = 0; wb_we = 1; settle();
        chk("fwd_x0", 32'(fwd_b), 32'h0);
        step(); idle();
        ex_rs2 = 9; wb_rd = 9; wb_we = 1; mem_rd = 8; mem_we = 1; settle();
        chk("fwd_wb", 32'(fwd_b), 32'h2);

        // Load-use bubble then clear
        step(); idle();
        ex_is_load = 1; ex_we = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; settle();
        chk("lu_pc_stall", 32'(pc_stall), 32'h1);
        chk("lu_ifid_stall", 32'(ifid_stall), 32'h1);
        chk("lu_idex_flush", 32'(idex_flush), 32'h1);
        step(); ex_is_load = 0; ex_we = 0; ex_rd = 0; settle();
        chk("lu_clear", 32'({pc_stall, ifid_stall, idex_flush}), 32'h0);

        // Redirect beats load-use
        step();
        ex_is_load = 1; ex_rd = 7; ex_redirect = 1; ex_target = 12'h40; settle();
        chk("rd_pc_redirect", 32'(pc_redirect), 32'h1);
        chk("rd_pc_target", 32'(pc_target), 32'h40);
        chk("rd_flushes", 32'({ifid_flush, idex_flush}), 32'h3);
        chk("rd_pc_stall", 32'(pc_stall), 32'h0);

        // Halt drain from a fresh counter
        do_reset();
        step(); idle(); id_halt = 1; settle();            // cycle t
        chk("hd_t_halt", 32'(halt), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step(); idle(); wb_valid = 1; ex_redirect = (k == 2); ex_target = 12'h80;
            settle();
            chk("hd_drain_halt", 32'(halt), 32'h0);
            chk("hd_drain_redirect", 32'(pc_redirect), 32'h0);
        end
        step(); idle(); settle();                          // cycle t+4
        chk("hd_halt", 32'(halt), 32'h1);
        chk("hd_num_inst", num_inst, 32'd3);
        step(); settle();
        chk("hd_sticky", 32'(halt), 32'h1);

        // Wrong-path halt
        do_reset();
        step(); idle(); id_halt = 1; ex_redirect = 1; ex_target = 12'h10; settle();
        chk("wp_pc_stall", 32'(pc_stall), 32'h0);
        for (int k = 0; k < 6; k++) begin
            step(); idle(); settle();
            chk("wp_halt", 32'(halt), 32'h0);
        end

        // Reset mid-drain
        do_reset();
        step(); idle(); wb_valid = 1; settle();
        step(); idle(); id_halt = 1; wb_valid = 1; settle();  // t
        step(); idle(); wb_valid = 1; settle();               // t+1
        step(); idle(); RSTn = 0; settle();                   // t+2
        step(); RSTn = 1; idle(); settle();                   // t+3
        chk("rmd_num_inst", num_inst, 32'h0);
        chk("rmd_halt", 32'(halt), 32'h0);
        chk("rmd_pc_stall", 32'(pc_stall), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(); idle(); settle();
            chk("rmd_run", 32'({halt, pc_stall}), 32'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            RSTn        = ($urandom_range(0, 59) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            id_halt     = ($urandom_range(0, 24) == 0);
            ex_rs1      = 5'($urandom_range(0, 3));
            ex_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            ex_we       = 1'($urandom);
            ex_is_load  = 1'($urandom);
            mem_rd      = 5'($urandom_range(0, 3));
            mem_we      = 1'($urandom);
            wb_rd       = 5'($urandom_range(0, 3));
            wb_we       = 1'($urandom);
            wb_valid    = 1'($urandom);
            ex_redirect = ($urandom_range(0, 7) == 0);
            ex_target   = PC_W'($urandom);
        end
        step(); idle(); RSTn = 1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
